// File: rtl/sig_filter_pkg.sv
// Shared definitions for the sig_glitch_filter slice.
//   - FSM state encoding for the level qualifier
//   - event record layout {rise, stamp} (shown here at the default width)
//   - default configuration constants
package sig_filter_pkg;

  localparam int unsigned DefaultFiltLen = 3;
  localparam int unsigned DefaultCntW    = 8;

  typedef enum logic [1:0] {
    ST_LO      = 2'd0,
    ST_PEND_HI = 2'd1,
    ST_HI      = 2'd2,
    ST_PEND_LO = 2'd3
  } filt_state_e;

  // Event record: rise flag in the MSB, cycle stamp below it.
  typedef struct packed {
    logic                   rise;
    logic [DefaultCntW-1:0] stamp;
  } evt_rec_t;

endpackage

// File: rtl/sig_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset, clears both stages to 0
//   d_i - asynchronous input
//   q_o - synchronized output (two clocks of latency)
module sig_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sig_glitch_filter.sv
// Glitch filter for a raw 1-bit gate-stage output. A new level must be seen for FILT_LEN
// consecutive sampled cycles before it is accepted; each accepted edge is reported as a
// timestamped event through a one-entry valid/ready buffer. Rejected pulses are counted.
// Build option: define SIG_GLITCH_FILTER_SYNC_EN to put a 2-flop synchronizer in front of the
// input sample register (adds 2 cycles of latency, for c_in from another clock domain).
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   c_in       - raw input signal
//   filt_out   - filtered level
//   evt_valid  - event pending
//   evt_ready  - consumer accepts the pending event when high with evt_valid
//   evt_rise   - 1 = rising edge event, 0 = falling
//   evt_time   - cycle counter value at the qualifying edge
//   glitch_cnt - rejected pulse count, saturating
//   overrun    - sticky, an event was dropped because the buffer was full
module sig_glitch_filter
  import sig_filter_pkg::*;
#(
  parameter int unsigned FILT_LEN = DefaultFiltLen,
  parameter int unsigned CNT_W    = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_in,
  output logic             filt_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_rise,
  output logic [CNT_W-1:0] evt_time,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             overrun
);

  localparam int unsigned    RcW   = $clog2(FILT_LEN + 1);
  localparam logic [RcW-1:0] RcMax = RcW'(FILT_LEN);
  localparam logic [RcW-1:0] RcOne = RcW'(1);

  typedef struct packed {
    logic             rise;
    logic [CNT_W-1:0] stamp;
  } evt_t;

  // ---------------------------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------------------------
  logic s_src;
  logic s_q;

`ifdef SIG_GLITCH_FILTER_SYNC_EN
  sig_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (c_in),
    .q_o (s_src)
  );
`else
  assign s_src = c_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 1'b0;
    end else begin
      s_q <= s_src;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Qualification FSM
  // ---------------------------------------------------------------------------------------------
  filt_state_e    state_q, state_d;
  logic [RcW-1:0] rc_q, rc_d;
  logic [RcW-1:0] rc_inc;
  logic           filt_q, filt_d;
  logic           new_evt;
  logic           new_rise;
  logic           glitch;

  assign rc_inc = rc_q + RcOne;

  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q;
    filt_d   = filt_q;
    new_evt  = 1'b0;
    new_rise = 1'b0;
    glitch   = 1'b0;
    unique case (state_q)
      ST_LO: begin
        if (s_q) begin
          if (RcMax == RcOne) begin
            state_d  = ST_HI;
            rc_d     = '0;
            filt_d   = 1'b1;
            new_evt  = 1'b1;
            new_rise = 1'b1;
          end else begin
            state_d = ST_PEND_HI;
            rc_d    = RcOne;
          end
        end
      end
      ST_PEND_HI: begin
        if (s_q) begin
          if (rc_inc == RcMax) begin
            state_d  = ST_HI;
            rc_d     = '0;
            filt_d   = 1'b1;
            new_evt  = 1'b1;
            new_rise = 1'b1;
          end else begin
            rc_d = rc_inc;
          end
        end else begin
          state_d = ST_LO;
          rc_d    = '0;
          glitch  = 1'b1;
        end
      end
      ST_HI: begin
        if (!s_q) begin
          if (RcMax == RcOne) begin
            state_d = ST_LO;
            rc_d    = '0;
            filt_d  = 1'b0;
            new_evt = 1'b1;
          end else begin
            state_d = ST_PEND_LO;
            rc_d    = RcOne;
          end
        end
      end
      ST_PEND_LO: begin
        if (!s_q) begin
          if (rc_inc == RcMax) begin
            state_d = ST_LO;
            rc_d    = '0;
            filt_d  = 1'b0;
            new_evt = 1'b1;
          end else begin
            rc_d = rc_inc;
          end
        end else begin
          state_d = ST_HI;
          rc_d    = '0;
          glitch  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LO;
      rc_q    <= '0;
      filt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      filt_q  <= filt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Timestamp and glitch counter
  // ---------------------------------------------------------------------------------------------
  logic [CNT_W-1:0] ts_q;
  logic [CNT_W-1:0] glitch_q, glitch_d;

  always_comb begin
    glitch_d = glitch_q;
    if (glitch && (glitch_q != {CNT_W{1'b1}})) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      glitch_q <= '0;
    end else begin
      ts_q     <= ts_q + 1'b1;
      glitch_q <= glitch_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // One-entry event buffer
  // ---------------------------------------------------------------------------------------------
  logic evt_vld_q, evt_vld_d;
  evt_t evt_q, evt_d;
  logic ovr_q, ovr_d;
  logic accept;

  assign accept = evt_vld_q & evt_ready;

  always_comb begin
    evt_vld_d = evt_vld_q;
    evt_d     = evt_q;
    ovr_d     = ovr_q;
    if (new_evt && (!evt_vld_q || accept)) begin
      // Empty, or being drained on this same edge: the new event takes the slot.
      evt_vld_d   = 1'b1;
      evt_d.rise  = new_rise;
      evt_d.stamp = ts_q;
    end else if (accept) begin
      evt_vld_d = 1'b0;
    end
    if (new_evt && evt_vld_q && !evt_ready) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_vld_q <= 1'b0;
      evt_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      evt_vld_q <= evt_vld_d;
      evt_q     <= evt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign filt_out   = filt_q;
  assign evt_valid  = evt_vld_q;
  assign evt_rise   = evt_q.rise;
  assign evt_time   = evt_q.stamp;
  assign glitch_cnt = glitch_q;
  assign overrun    = ovr_q;

endmodule
